// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared widths and the zero-register index
// for the architectural integer register file.
package reg_file_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: read/write port bundle of the register file.
// master: core side (drives indices/write), slave: reg_file.
interface reg_file_if;
  import reg_file_pkg::*;

  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [ADDR_W-1:0] A3;
  logic              WE3;
  logic [DATA_W-1:0] WD3;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;

  modport master (
    output A1, A2, A3, WE3, WD3,
    input  RD1, RD2
  );

  modport slave (
    input  A1, A2, A3, WE3, WD3,
    output RD1, RD2
  );

endinterface

// File: rtl/reg_file.sv
// reg_file: 32x32 RV32 register file, x0 hardwired to zero.
// Ports: clk, rst (sync, active-high), rf (reg_file_if.slave):
//   A1/A2 read indices -> RD1/RD2 (combinational),
//   A3/WE3/WD3 write port (commits on rising clk).
// Build option: REG_FILE_BYPASS_EN forwards WD3 to a read
// port that addresses the write target in the same cycle.
module reg_file
  import reg_file_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  reg_file_if.slave  rf
);

  // x0 is never stored; reads of index 0 are forced to zero.
  logic [DATA_W-1:0] regs [1:NREGS-1];

  logic wr_ok;

  assign wr_ok = rf.WE3 && (rf.A3 != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[rf.A3] <= rf.WD3;
    end
  end

  logic [DATA_W-1:0] rd1_st;
  logic [DATA_W-1:0] rd2_st;

  always_comb begin
    rd1_st = '0;
    rd2_st = '0;
    if (rf.A1 != REG_ZERO) rd1_st = regs[rf.A1];
    if (rf.A2 != REG_ZERO) rd2_st = regs[rf.A2];
  end

`ifdef REG_FILE_BYPASS_EN
  // Forwarding is suppressed under reset: the write will be dropped.
  logic fwd1;
  logic fwd2;

  assign fwd1 = wr_ok && !rst && (rf.A1 == rf.A3);
  assign fwd2 = wr_ok && !rst && (rf.A2 == rf.A3);

  assign rf.RD1 = fwd1 ? rf.WD3 : rd1_st;
  assign rf.RD2 = fwd2 ? rf.WD3 : rd2_st;
`else
  assign rf.RD1 = rd1_st;
  assign rf.RD2 = rd2_st;
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: randomized + directed scoreboard bench for reg_file.
// Driver pushes expected reads; negedge monitor pops and compares.
module tb_reg_file;

  logic clk;
  logic rst;

  reg_file_if rf ();

  reg_file dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    int          id;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  bit          chk_valid;
  int          checks;
  int          errors;
  int          step_id;

  function automatic logic [31:0] ref_read(
    input logic [4:0]  a,
    input bit          r,
    input bit          w,
    input logic [4:0]  a3,
    input logic [31:0] wd
  );
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : model[a];
`ifdef REG_FILE_BYPASS_EN
    if (w && !r && a3 != 5'd0 && a == a3) v = wd;
`endif
    return v;
  endfunction

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(
    input bit          r,
    input bit          w,
    input logic [4:0]  a1,
    input logic [4:0]  a2,
    input logic [4:0]  a3,
    input logic [31:0] wd,
    input bit          chk
  );
    exp_t e;
    rst    = r;
    rf.WE3 = w;
    rf.A1  = a1;
    rf.A2  = a2;
    rf.A3  = a3;
    rf.WD3 = wd;
    if (chk) begin
      e.e1 = ref_read(a1, r, w, a3, wd);
      e.e2 = ref_read(a2, r, w, a3, wd);
      e.id = step_id;
      sb.push_back(e);
    end
    chk_valid = chk;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (w && a3 != 5'd0) begin
      model[a3] = wd;
    end
    step_id++;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, 5'd0, 5'd0, a, d, 1'b0);
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    step(1'b0, 1'b0, a1, a2, 5'd0, 32'd0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (chk_valid) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL sb_empty step=%0d", step_id);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks += 2;
        if (rf.RD1 !== e.e1) begin
          errors++;
          $display("FAIL rd1 step=%0d A1=%0d got=%h exp=%h",
                   e.id, rf.A1, rf.RD1, e.e1);
        end
        if (rf.RD2 !== e.e2) begin
          errors++;
          $display("FAIL rd2 step=%0d A2=%0d got=%h exp=%h",
                   e.id, rf.A2, rf.RD2, e.e2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a1, a2, a3;
    checks    = 0;
    errors    = 0;
    step_id   = 0;
    chk_valid = 1'b0;
    rst       = 1'b1;
    rf.WE3    = 1'b0;
    rf.A1     = '0;
    rf.A2     = '0;
    rf.A3     = '0;
    rf.WD3    = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(posedge clk);
    #1;

    // reset then read every index on both ports
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

    // write / readback
    wr(5'd5, 32'hDEADBEEF);
    rd(5'd5, 5'd5);
    rd(5'd6, 5'd5);

    // x0 protection
    wr(5'd0, 32'hFFFFFFFF);
    rd(5'd0, 5'd0);

    // same-cycle read of the write target
    wr(5'd7, 32'h11111111);
    step(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h22222222, 1'b1);
    rd(5'd7, 5'd7);

    // reset beats a simultaneous write
    wr(5'd3, 32'h12345678);
    rd(5'd3, 5'd7);
    step(1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'hCAFEBABE, 1'b1);
    rd(5'd3, 5'd7);

    // WE3 low leaves state untouched
    wr(5'd10, 32'h0BADF00D);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 5'd10, 5'd9, 5'd9, 32'hA5A5A5A5, 1'b1);
    rd(5'd10, 5'd9);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
           a1, a2, a3, $urandom, 1'b1);
    end

    chk_valid = 1'b0;
    @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
